jtag_ir_dr_path: RTL and testbench
==================================

Name: jtag_ir_dr_path

Overview:
Instruction-register and data-register scan datapath that sits directly downstream of the TAP controller state machine. It consumes the controller's 4-bit state code and performs IEEE 1149.1 capture, shift and update on the IR and the selected DR. It holds three DRs: BYPASS, IDCODE and an 8-bit user DR. It drives TDO and its output enable back to the pin.

Parameters:
IR_WIDTH, 4, instruction register width (min 2)
UDR_WIDTH, 8, user data register width
IDCODE_VALUE, 32'h1A2B_3C4D, device ID; bit 0 must be 1
OP_IDCODE, 4'b0001, IDCODE opcode
OP_USERDR, 4'b1000, user DR opcode
IR_CAPTURE, 4'b0001, value loaded in Capture-IR; bits [1:0] must be 2'b01

Ports:
TCK  in  1  test clock
TRST  in  1  reset
TDI  in  1  serial test data in
tap_state  in  4  current TAP state code from controller
udr_capture_in  in  UDR_WIDTH  parallel value captured into user DR
TDO  out  1  serial test data out
tdo_en  out  1  TDO output enable
ir_out  out  IR_WIDTH  active instruction
udr_out  out  UDR_WIDTH  user DR parallel output
udr_update  out  1  user DR update strobe

Behaviour:
- Reset is TRST, asynchronous, active-high. While TRST is high: ir_out=OP_IDCODE, IR shift reg=0, all DR shift regs=0, TDO=0, tdo_en=0, udr_out=0, udr_update=0.
- tap_state codes: 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauseDR, 7 Ex2DR, 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauseIR, 14 Ex2IR, 15 UpdIR.
- Posedge TCK actions:
  - CapIR: ir_sr <= IR_CAPTURE.
  - ShIR: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]}.
  - CapDR (selected DR only): bypass <= 0; id_sr <= IDCODE_VALUE; udr_sr <= udr_capture_in.
  - ShDR: selected DR shifts right, TDI enters the MSB. A 1-bit bypass register simply loads TDI.
  - All other states: shift registers hold.
- DR selection is decoded from ir_out:
  - OP_IDCODE selects IDCODE.
  - OP_USERDR selects the user DR.
  - All-ones and every undefined opcode select BYPASS.
- Negedge TCK actions:
  - UpdIR: ir_out <= ir_sr.
  - TLR: ir_out <= OP_IDCODE.
  - UpdDR with user DR selected: udr_out <= udr_sr and udr_update <= 1.
  - Otherwise udr_update <= 0, so the strobe is exactly one TCK period wide, negedge to negedge.
- TDO / tdo_en, updated on negedge TCK:
  - ShIR: tdo_en=1, TDO=ir_sr[0].
  - ShDR: tdo_en=1, TDO = bit 0 of the selected DR.
  - Any other state: tdo_en=0, TDO=0.
  - The first TDO bit is therefore the captured LSB, valid from the negedge after entering the shift state.
- Pausing (Pause/Exit states) holds all shift contents, so re-entering Shift via Ex2 continues the stream without loss.
- Update with no preceding Capture latches whatever the shift register holds. No hazard checks.
- An opcode change at UpdIR takes effect for the next CapDR. DR contents are not cleared.
- TRST mid-shift aborts immediately: outputs return to reset values asynchronously and no update occurs.
- tap_state is sampled as-is and is assumed synchronous to TCK from the controller. Codes are exhaustive, so there is no illegal state.

Test Plan:
- TRST pulse, then CapDR→ShDR for 32 cycles with TDI=0 → TDO LSB-first yields 32'h1A2B3C4D, tdo_en=1 during ShDR, ir_out=4'b0001.
- CapIR→ShIR for 4 cycles shifting TDI=1,1,1,1 → TDO=1,0,0,0; UpdIR → ir_out=4'b1111. Then CapDR→ShDR with TDI=1,0,1,1 → TDO=0,1,0,1 (one-cycle bypass delay).
- Load IR 4'b1000, udr_capture_in=8'hC3, CapDR, shift 8 bits of TDI=8'h5A LSB-first → TDO=8'hC3 LSB-first. UpdDR → udr_out=8'h5A, udr_update high for exactly one TCK, 0 after.
- Shift 4 bits of user DR, go Ex1DR→PauseDR (3 cycles)→Ex2DR→ShDR, shift the remaining 4 → TDO stream identical to an uninterrupted 8-bit shift and udr_out correct after UpdDR.
- Load undefined IR 4'b0110 → DR behaves as bypass: the first captured bit is 0. Then drive tap_state=0 for one cycle → ir_out=4'b0001.
- Assert TRST during the 5th ShDR cycle of the user DR → TDO=0, tdo_en=0, udr_out unchanged at 0, udr_update never asserts, ir_out=4'b0001.

Source files
------------

// File: rtl/jtag_ir_dr_path.sv
// IEEE 1149.1 IR/DR scan datapath driven by the TAP controller state code.
// Capture/shift happen on posedge TCK; update and TDO launch happen on negedge TCK.
module jtag_ir_dr_path #(
  parameter int                  IR_WIDTH     = 4,
  parameter int                  UDR_WIDTH    = 8,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1A2B_3C4D,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = 4'b0001,
  parameter logic [IR_WIDTH-1:0] OP_USERDR    = 4'b1000,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE   = 4'b0001
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic                 TDI,
  input  logic [3:0]           tap_state,
  input  logic [UDR_WIDTH-1:0] udr_capture_in,
  output logic                 TDO,
  output logic                 tdo_en,
  output logic [IR_WIDTH-1:0]  ir_out,
  output logic [UDR_WIDTH-1:0] udr_out,
  output logic                 udr_update
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SELDR, S_CAPDR, S_SHDR, S_EX1DR, S_PAUSEDR, S_EX2DR,
    S_UPDDR, S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PAUSEIR, S_EX2IR, S_UPDIR
  } tap_state_e;

  tap_state_e st;
  assign st = tap_state_e'(tap_state);

  logic [IR_WIDTH-1:0]  ir_sr_q, ir_sr_d;
  logic                 byp_q, byp_d;
  logic [31:0]          id_sr_q, id_sr_d;
  logic [UDR_WIDTH-1:0] udr_sr_q, udr_sr_d;
  logic [IR_WIDTH-1:0]  ir_out_q, ir_out_d;
  logic [UDR_WIDTH-1:0] udr_out_q, udr_out_d;
  logic                 udr_update_q, udr_update_d;
  logic                 tdo_q, tdo_d;
  logic                 tdo_en_q, tdo_en_d;

  // Any opcode other than IDCODE/USERDR (including all-ones) falls back to BYPASS.
  logic sel_id, sel_udr, dr_lsb;
  assign sel_id  = (ir_out_q == OP_IDCODE);
  assign sel_udr = (ir_out_q == OP_USERDR);
  assign dr_lsb  = sel_id ? id_sr_q[0] : (sel_udr ? udr_sr_q[0] : byp_q);

  always_comb begin
    ir_sr_d  = ir_sr_q;
    byp_d    = byp_q;
    id_sr_d  = id_sr_q;
    udr_sr_d = udr_sr_q;
    case (st)
      S_CAPIR: ir_sr_d = IR_CAPTURE;
      S_SHIR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
      S_CAPDR: begin
        if (sel_id)       id_sr_d  = IDCODE_VALUE;
        else if (sel_udr) udr_sr_d = udr_capture_in;
        else              byp_d    = 1'b0;
      end
      S_SHDR: begin
        if (sel_id)       id_sr_d  = {TDI, id_sr_q[31:1]};
        else if (sel_udr) udr_sr_d = {TDI, udr_sr_q[UDR_WIDTH-1:1]};
        else              byp_d    = TDI;
      end
      default: ;
    endcase
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_sr_q  <= '0;
      byp_q    <= 1'b0;
      id_sr_q  <= '0;
      udr_sr_q <= '0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      byp_q    <= byp_d;
      id_sr_q  <= id_sr_d;
      udr_sr_q <= udr_sr_d;
    end
  end

  always_comb begin
    ir_out_d     = ir_out_q;
    udr_out_d    = udr_out_q;
    udr_update_d = 1'b0;
    tdo_d        = 1'b0;
    tdo_en_d     = 1'b0;
    case (st)
      S_TLR:   ir_out_d = OP_IDCODE;
      S_UPDIR: ir_out_d = ir_sr_q;
      S_UPDDR: begin
        if (sel_udr) begin
          udr_out_d    = udr_sr_q;
          udr_update_d = 1'b1;
        end
      end
      S_SHIR: begin
        tdo_en_d = 1'b1;
        tdo_d    = ir_sr_q[0];
      end
      S_SHDR: begin
        tdo_en_d = 1'b1;
        tdo_d    = dr_lsb;
      end
      default: ;
    endcase
  end

  // Negedge launch keeps TDO stable around the controller's posedge sampling.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_out_q     <= OP_IDCODE;
      udr_out_q    <= '0;
      udr_update_q <= 1'b0;
      tdo_q        <= 1'b0;
      tdo_en_q     <= 1'b0;
    end else begin
      ir_out_q     <= ir_out_d;
      udr_out_q    <= udr_out_d;
      udr_update_q <= udr_update_d;
      tdo_q        <= tdo_d;
      tdo_en_q     <= tdo_en_d;
    end
  end

  assign TDO        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign ir_out     = ir_out_q;
  assign udr_out    = udr_out_q;
  assign udr_update = udr_update_q;

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Directed plus randomized bench for jtag_ir_dr_path against a step-level scan model.
module tb_jtag_ir_dr_path;

  logic       TCK;
  logic       TRST;
  logic       TDI;
  logic [3:0] tap_state;
  logic [7:0] udr_capture_in;
  logic       TDO;
  logic       tdo_en;
  logic [3:0] ir_out;
  logic [7:0] udr_out;
  logic       udr_update;

  jtag_ir_dr_path dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state),
    .udr_capture_in(udr_capture_in), .TDO(TDO), .tdo_en(tdo_en),
    .ir_out(ir_out), .udr_out(udr_out), .udr_update(udr_update)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: contents of each register as plain values.
  logic [3:0]  m_ir_sr, m_ir;
  logic        m_byp;
  logic [31:0] m_id;
  logic [7:0]  m_udr_sr, m_udr_out;
  logic        m_upd;
  logic        last_tdo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ir_sr = 4'h0; m_ir = 4'h1; m_byp = 1'b0; m_id = 32'h0;
    m_udr_sr = 8'h0; m_udr_out = 8'h0; m_upd = 1'b0;
  endtask

  // One TCK cycle in state st; called just after a posedge.
  task automatic step(input logic [3:0] st, input logic tdi);
    logic e_tdo, e_en;
    logic is_id, is_udr;
    tap_state = st;
    TDI = tdi;
    is_id  = (m_ir == 4'h1);
    is_udr = (m_ir == 4'h8);
    e_en  = (st == 4'd4) || (st == 4'd11);
    e_tdo = 1'b0;
    if (st == 4'd11) e_tdo = m_ir_sr[0];
    else if (st == 4'd4) e_tdo = is_id ? m_id[0] : (is_udr ? m_udr_sr[0] : m_byp);
    m_upd = 1'b0;
    if (st == 4'd15) m_ir = m_ir_sr;
    if (st == 4'd0)  m_ir = 4'h1;
    if (st == 4'd8 && is_udr) begin
      m_udr_out = m_udr_sr;
      m_upd = 1'b1;
    end
    @(negedge TCK); #1;
    chk("tdo", 64'(TDO), 64'(e_tdo));
    chk("tdo_en", 64'(tdo_en), 64'(e_en));
    chk("ir_out", 64'(ir_out), 64'(m_ir));
    chk("udr_out", 64'(udr_out), 64'(m_udr_out));
    chk("udr_update", 64'(udr_update), 64'(m_upd));
    last_tdo = TDO;
    is_id  = (m_ir == 4'h1);
    is_udr = (m_ir == 4'h8);
    case (st)
      4'd10: m_ir_sr = 4'b0001;
      4'd11: m_ir_sr = (m_ir_sr >> 1) | (4'(tdi) << 3);
      4'd3: begin
        if (is_id) m_id = 32'h1A2B_3C4D;
        else if (is_udr) m_udr_sr = udr_capture_in;
        else m_byp = 1'b0;
      end
      4'd4: begin
        if (is_id) m_id = (m_id >> 1) | (32'(tdi) << 31);
        else if (is_udr) m_udr_sr = (m_udr_sr >> 1) | (8'(tdi) << 7);
        else m_byp = tdi;
      end
      default: ;
    endcase
    @(posedge TCK); #1;
  endtask

  task automatic load_ir(input logic [3:0] val, output logic [3:0] col);
    col = 4'h0;
    step(4'd2, 1'b0); step(4'd9, 1'b0); step(4'd10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'd11, val[i]);
      col[i] = last_tdo;
    end
    step(4'd12, 1'b0); step(4'd15, 1'b0); step(4'd1, 1'b0);
  endtask

  // SelDR, CapDR, n shifts, Ex1DR; caller decides on update.
  task automatic scan_dr(input int n, input logic [63:0] tdi_w, output logic [63:0] col);
    col = 64'h0;
    step(4'd2, 1'b0); step(4'd3, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(4'd4, tdi_w[i]);
      col[i] = last_tdo;
    end
    step(4'd5, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ircol;
    logic [63:0] col, w;
    logic [7:0]  cap;
    int          n;
    TRST = 1'b1; TDI = 1'b0; tap_state = 4'd0; udr_capture_in = 8'h00;
    m_reset();
    repeat (2) @(posedge TCK);
    #1;
    chk("rst_ir_out", 64'(ir_out), 64'h1);
    chk("rst_tdo", 64'(TDO), 64'h0);
    chk("rst_tdo_en", 64'(tdo_en), 64'h0);
    chk("rst_udr_out", 64'(udr_out), 64'h0);
    chk("rst_udr_update", 64'(udr_update), 64'h0);
    TRST = 1'b0;

    // IDCODE read-out after reset
    step(4'd1, 1'b0);
    scan_dr(32, 64'h0, col);
    chk("idcode_stream", col, 64'h1A2B_3C4D);
    chk("idcode_ir", 64'(ir_out), 64'h1);
    step(4'd8, 1'b0); step(4'd1, 1'b0);

    // All-ones IR -> bypass with one-cycle delay
    load_ir(4'hF, ircol);
    chk("ir_capture_out", 64'(ircol), 64'h1);
    chk("ir_all_ones", 64'(ir_out), 64'hF);
    scan_dr(4, 64'b1101, col);
    chk("bypass_stream", col, 64'b1010);
    step(4'd8, 1'b0); step(4'd1, 1'b0);

    // User DR capture/shift/update
    load_ir(4'h8, ircol);
    udr_capture_in = 8'hC3;
    scan_dr(8, 64'h5A, col);
    chk("udr_capture_stream", col, 64'hC3);
    step(4'd8, 1'b0);
    chk("udr_update_pulse", 64'(udr_update), 64'h1);
    chk("udr_out_5a", 64'(udr_out), 64'h5A);
    step(4'd1, 1'b0);
    chk("udr_update_drop", 64'(udr_update), 64'h0);

    // Pause in the middle of a user DR shift
    cap = 8'($urandom);
    w = 64'($urandom_range(0, 255));
    udr_capture_in = cap;
    col = 64'h0;
    step(4'd2, 1'b0); step(4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin step(4'd4, w[i]); col[i] = last_tdo; end
    step(4'd5, 1'b0); step(4'd6, 1'b0); step(4'd6, 1'b0); step(4'd6, 1'b0); step(4'd7, 1'b0);
    for (int i = 4; i < 8; i++) begin step(4'd4, w[i]); col[i] = last_tdo; end
    step(4'd5, 1'b0); step(4'd8, 1'b0);
    chk("pause_stream", col, 64'(cap));
    chk("pause_udr_out", 64'(udr_out), w);
    step(4'd1, 1'b0);

    // Undefined opcode -> bypass, then TLR restores IDCODE
    load_ir(4'h6, ircol);
    step(4'd2, 1'b0); step(4'd3, 1'b0);
    step(4'd4, 1'b1);
    chk("undef_first_bit", 64'(last_tdo), 64'h0);
    step(4'd4, 1'b0);
    chk("undef_second_bit", 64'(last_tdo), 64'h1);
    step(4'd5, 1'b0); step(4'd8, 1'b0);
    step(4'd0, 1'b0);
    chk("tlr_ir_out", 64'(ir_out), 64'h1);
    step(4'd1, 1'b0);

    // Randomized directed scans over a mix of opcodes
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 2))
        0: load_ir(4'h1, ircol);
        1: load_ir(4'h8, ircol);
        default: load_ir(4'($urandom), ircol);
      endcase
      udr_capture_in = 8'($urandom);
      n = $urandom_range(1, 40);
      w = {32'($urandom), 32'($urandom)};
      scan_dr(n, w, col);
      step(4'd8, 1'b0); step(4'd1, 1'b0);
    end

    // Free-running random state codes
    for (int k = 0; k < 300; k++) begin
      udr_capture_in = 8'($urandom);
      step(4'($urandom_range(0, 15)), 1'($urandom));
    end

    // TRST during the 5th user DR shift cycle
    TRST = 1'b1;
    m_reset();
    @(posedge TCK); #1;
    TRST = 1'b0;
    load_ir(4'h8, ircol);
    udr_capture_in = 8'hA5;
    step(4'd2, 1'b0); step(4'd3, 1'b0);
    for (int i = 0; i < 4; i++) step(4'd4, 1'b1);
    tap_state = 4'd4; TDI = 1'b1;
    @(negedge TCK); #1;
    TRST = 1'b1;
    #1;
    m_reset();
    chk("trst_tdo", 64'(TDO), 64'h0);
    chk("trst_tdo_en", 64'(tdo_en), 64'h0);
    chk("trst_udr_out", 64'(udr_out), 64'h0);
    chk("trst_udr_update", 64'(udr_update), 64'h0);
    chk("trst_ir_out", 64'(ir_out), 64'h1);
    @(posedge TCK); #1;
    TRST = 1'b0;
    step(4'd5, 1'b0); step(4'd8, 1'b0);
    chk("trst_no_update", 64'(udr_update), 64'h0);
    chk("trst_udr_out_after", 64'(udr_out), 64'h0);
    step(4'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
